// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    localparam int          MAX_LEN_DEF     = 8;
    localparam int          CNT_W_DEF       = 8;
    localparam logic [7:0]  RST_PATTERN_DEF = 8'b0000_1011;
    localparam int          RST_LEN_DEF     = 4;
    localparam logic        RST_OVERLAP_DEF = 1'b1;

    // Limit a requested pattern length to the hardware window.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

    // Low-bit mask with 'len' ones; callers truncate it to their window width.
    function automatic logic [31:0] mask_bits(input int unsigned len);
        if (len >= 32) begin
            return '1;
        end
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Config, serial input and result signals of the pattern detector.
// Input qualification: a bit is consumed on a rising clk edge when in_valid=1
// and cfg_load=0; there is no back-pressure, so the detector never stalls
// the sender. detected is a one-cycle pulse with no acknowledge.
interface seq_detector_prog_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = CNT_W_DEF
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               cnt_clr;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   cur_len;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output in_valid, in_bit, cnt_clr,
        input  detected, match_count, cur_len
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  in_valid, in_bit, cnt_clr,
        output detected, match_count, cur_len
    );
endinterface

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    // Count up on inc, hold at all-ones, clear on request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;
endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with registered detect
// pulse and saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int               MAX_LEN     = MAX_LEN_DEF,
    parameter int               LEN_W       = $clog2(MAX_LEN + 1),
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(RST_PATTERN_DEF),
    parameter int               RST_LEN     = RST_LEN_DEF,
    parameter logic             RST_OVERLAP = RST_OVERLAP_DEF
) (
    input logic               clk,
    input logic               rst,
    seq_detector_prog_if.slave bus
);
    // The oldest window bit is shifted out on every accepted bit, so only
    // MAX_LEN-1 bits of history need storing; cand rebuilds the full window.
    logic [MAX_LEN-2:0] hist_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_cl;
    logic [LEN_W:0]     fill_p1;
    logic               ovl_q;
    logic               det_q;
    logic               accept;
    logic               match;
    logic [CNT_W-1:0]   count;

    // Candidate window, length mask and match decision for the incoming bit.
    always_comb begin
        accept     = bus.in_valid & ~bus.cfg_load;
        cand       = {hist_q, bus.in_bit};
        mask       = MAX_LEN'(mask_bits(32'(len_q)));
        fill_p1    = {1'b0, fill_q} + (LEN_W + 1)'(1);
        fill_inc   = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_p1[LEN_W-1:0];
        cfg_len_cl = LEN_W'(clamp_len(32'(bus.cfg_len), MAX_LEN));
        match      = accept
                     && (len_q != '0)
                     && (fill_p1 >= {1'b0, len_q})
                     && ((cand & mask) == (pat_q & mask));
    end

    // Configuration registers, reloaded only by cfg_load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= RST_PATTERN;
            len_q <= LEN_W'(RST_LEN);
            ovl_q <= RST_OVERLAP;
        end else if (bus.cfg_load) begin
            pat_q <= bus.cfg_pattern;
            len_q <= cfg_len_cl;
            ovl_q <= bus.cfg_overlap;
        end
    end

    // History shift and fill tracking; a non-overlap match restarts the fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (bus.cfg_load) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (accept) begin
            hist_q <= cand[MAX_LEN-2:0];
            fill_q <= (match && !ovl_q) ? '0 : fill_inc;
        end
    end

    // One-cycle detect pulse, one clock after the completing bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_q <= 1'b0;
        end else begin
            det_q <= match;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.cnt_clr),
        .inc  (match),
        .count(count)
    );

    assign bus.detected    = det_q;
    assign bus.match_count = count;
    assign bus.cur_len     = len_q;
endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: default config, overlap modes,
// valid gaps, length clamping, counter saturation/clear, reset and reload.
module tb_seq_detector_prog;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    seq_detector_prog_if #(.CNT_W(8)) bus ();
    seq_detector_prog_if #(.CNT_W(2)) bus2 ();

    seq_detector_prog #(.CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    seq_detector_prog #(.CNT_W(2)) dut2 (
        .clk(clk),
        .rst(rst),
        .bus(bus2.slave)
    );

    // The narrow-counter instance sees exactly the same stimulus.
    assign bus2.cfg_load    = bus.cfg_load;
    assign bus2.cfg_pattern = bus.cfg_pattern;
    assign bus2.cfg_len     = bus.cfg_len;
    assign bus2.cfg_overlap = bus.cfg_overlap;
    assign bus2.in_valid    = bus.in_valid;
    assign bus2.in_bit      = bus.in_bit;
    assign bus2.cnt_clr     = bus.cnt_clr;

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; returns #1 after the rising edge.
    task automatic drive(input logic v, input logic b, input logic clr);
        @(negedge clk);
        bus.cfg_load = 1'b0;
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.cnt_clr  = clr;
        @(posedge clk);
        #1;
        bus.cnt_clr  = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic b, input logic exp_det, input string tag);
        drive(1'b1, b, 1'b0);
        check(tag, 32'(bus.detected), 32'(exp_det));
    endtask

    // Bits and expected detect flags are given MSB-first (first bit sent = bit n-1).
    task automatic send_seq(input int n, input logic [31:0] bits, input logic [31:0] exps,
                            input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], exps[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            check($sformatf("%s_%0d", tag, i), 32'(bus.detected), 32'd0);
        end
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                            input logic v, input logic b, input string tag);
        @(negedge clk);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ovl;
        bus.in_valid    = v;
        bus.in_bit      = b;
        bus.cnt_clr     = 1'b0;
        @(posedge clk);
        #1;
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b0;
        check({tag, "_det"}, 32'(bus.detected), 32'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst             = 1'b1;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_bit      = 1'b0;
        bus.cnt_clr     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_det", 32'(bus.detected), 32'd0);
        check("rst_cnt", 32'(bus.match_count), 32'd0);
        check("rst_len", 32'(bus.cur_len), 32'd4);

        // 1: default 1011, overlap on.
        send_seq(7, 32'b1011011, 32'b0001001, "t1");
        check("t1_cnt", 32'(bus.match_count), 32'd2);

        // 2: pattern 1010 with and without overlap.
        load_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0, "t2_cfg_ovl");
        send_seq(8, 32'b10101010, 32'b00010101, "t2_ovl");
        check("t2_cnt_ovl", 32'(bus.match_count), 32'd5);
        load_cfg(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0, "t2_cfg_novl");
        send_seq(8, 32'b10101010, 32'b00010001, "t2_novl");
        check("t2_cnt_novl", 32'(bus.match_count), 32'd7);

        // 3: valid gap inside a match.
        load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, "t3_cfg");
        send(1'b1, 1'b0, "t3_b1");
        send(1'b0, 1'b0, "t3_b2");
        idle(5, "t3_gap");
        send(1'b1, 1'b0, "t3_b3");
        send(1'b1, 1'b1, "t3_b4");
        check("t3_cnt", 32'(bus.match_count), 32'd8);
        check("t3_cnt2_sat", 32'(bus2.match_count), 32'd3);

        // 4: length clamp and disabled detector.
        load_cfg(8'b1111_1111, 4'd9, 1'b1, 1'b0, 1'b0, "t4_cfg9");
        check("t4_len_clamp", 32'(bus.cur_len), 32'd8);
        load_cfg(8'b0000_0000, 4'd0, 1'b1, 1'b0, 1'b0, "t4_cfg0");
        check("t4_len0", 32'(bus.cur_len), 32'd0);
        for (int i = 0; i < 16; i++) begin
            send(1'($urandom_range(0, 1)), 1'b0, $sformatf("t4_rnd%0d", i));
        end
        check("t4_cnt", 32'(bus.match_count), 32'd8);

        // 5: counter clear, saturation, clear beats a coincident match.
        load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, "t5_cfg");
        drive(1'b0, 1'b0, 1'b1);
        check("t5_clr", 32'(bus.match_count), 32'd0);
        check("t5_clr2", 32'(bus2.match_count), 32'd0);
        send_seq(19, 32'b1011_011_011_011_011_011, 32'b0001_001_001_001_001_001, "t5");
        check("t5_cnt6", 32'(bus.match_count), 32'd6);
        check("t5_cnt2_sat", 32'(bus2.match_count), 32'd3);
        send(1'b0, 1'b0, "t5_c1");
        send(1'b1, 1'b0, "t5_c2");
        drive(1'b1, 1'b1, 1'b1);
        check("t5_clr_match_det", 32'(bus.detected), 32'd1);
        check("t5_clr_match_cnt", 32'(bus.match_count), 32'd0);
        check("t5_clr_match_cnt2", 32'(bus2.match_count), 32'd0);

        // 6: mid-stream reset restores defaults; cfg_load drops its bit.
        load_cfg(8'b0000_0000, 4'd5, 1'b0, 1'b0, 1'b0, "t6_cfg");
        check("t6_len5", 32'(bus.cur_len), 32'd5);
        send_seq(3, 32'b101, 32'b000, "t6_pre");
        load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, "t6_cfg_def");
        send_seq(3, 32'b101, 32'b000, "t6_part");
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_len", 32'(bus.cur_len), 32'd4);
        check("t6_async_det", 32'(bus.detected), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 1'b0, "t6_after_rst");
        send(1'b0, 1'b0, "t6_r1");
        send(1'b1, 1'b0, "t6_r2");
        load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1, "t6_load_drop");
        send_seq(4, 32'b1011, 32'b0001, "t6_post");
        check("t6_cnt", 32'(bus.match_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
